mesi_bus_arbiter: RTL and testbench
===================================

# mesi_bus_arbiter

Bus arbiter and transaction sequencer for the MESI snooping bus. It shares the single coherence bus among `N_CACHES` cache controllers using a round-robin grant. For the granted transaction it broadcasts the BusRd or BusRdX to all other caches, collects their shared and flush responses over a fixed snoop window, and extends the transaction while a dirty line is written back. It sits between the per-cache MESI controllers and the snoop broadcast network.

## Interface
- `N_CACHES`, 4, number of requesting caches (≥2)
- `SNOOP_CYCLES`, 2, snoop response window length in cycles (≥1)
- `FLUSH_CYCLES`, 4, extra cycles held when any snooper flushes (≥1)

- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req`  in  N_CACHES  per-cache bus request; held until `done`
- `req_rdx`  in  N_CACHES  per-cache op; 1 = BusRdX, 0 = BusRd; sampled with `req`
- `snoop_shared`  in  N_CACHES  snooper holds the line (S/E)
- `snoop_flush`  in  N_CACHES  snooper supplies a dirty line (was M)
- `gnt`  out  N_CACHES  one-hot grant to the owner
- `snoop_rd`  out  N_CACHES  one-cycle BusRd broadcast to non-owners
- `snoop_rdx`  out  N_CACHES  one-cycle BusRdX broadcast to non-owners
- `done`  out  N_CACHES  one-cycle completion pulse to the owner
- `shared_resp`  out  1  valid with `done`; a non-owner reported shared or flush
- `flush_resp`  out  1  valid with `done`; a non-owner flushed
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, GRANT, SNOOP, FLUSH, DONE. All outputs are registered.
- IDLE:
  - Any `req` bit set → pick the winner via round-robin.
  - Latch the owner index and `req_rdx[owner]`; go to GRANT.
- Round-robin: search starts at `rr_ptr` and wraps modulo N_CACHES. `rr_ptr` updates to `owner+1` (wrapping) on DONE.
- GRANT (1 cycle):
  - `gnt[owner]`=1.
  - `snoop_rd` or `snoop_rdx`, per the latched op, is asserted on every bit except `owner`.
  - Clear the sticky `sh_acc` and `fl_acc` flags; go to SNOOP.
- SNOOP (`SNOOP_CYCLES` cycles):
  - Each cycle, `sh_acc |= |(snoop_shared|snoop_flush) & ~onehot(owner)` and `fl_acc |= |(snoop_flush & ~onehot(owner))`.
  - At the end of the window: go to FLUSH if `fl_acc`, else DONE.
- FLUSH (`FLUSH_CYCLES` cycles): snoop inputs ignored; go to DONE.
- DONE (1 cycle): `done[owner]`=1, `shared_resp`=`sh_acc`, `flush_resp`=`fl_acc`; advance `rr_ptr`; go to IDLE.
- `gnt[owner]` stays high from GRANT through DONE inclusive.
- Owner's own `snoop_shared`/`snoop_flush` bits are always masked.
- `req` deasserted mid-transaction is ignored; the transaction completes and `done` still pulses.
- `req_rdx` changes after GRANT are ignored.
- A single cycle counter is shared by SNOOP and FLUSH, with width `$clog2(max(SNOOP_CYCLES,FLUSH_CYCLES)+1)`. It reloads on every state entry and never wraps.
- Reset (any state, including mid-transaction): next cycle state=IDLE, `rr_ptr`=0, counter=0, accumulators=0, all outputs 0. No `done` is issued for the aborted transaction.

## Timing
- Request seen high in cycle 0 (IDLE) → GRANT in cycle 1 → SNOOP in cycles 2..1+SNOOP_CYCLES.
- No flush: DONE in cycle 2+SNOOP_CYCLES (cycle 4 at defaults).
- Flush: adds FLUSH_CYCLES (DONE in cycle 8 at defaults).
- After DONE there is always one IDLE cycle. At defaults the next grant is no earlier than cycle 6.
- `snoop_rd`/`snoop_rdx` are high only in the GRANT cycle. `done`, `shared_resp` and `flush_resp` are high only in the DONE cycle.

## Structure
- Package `mesi_bus_pkg` holds:
  - state enum `bus_state_t` (IDLE/GRANT/SNOOP/FLUSH/DONE)
  - op typedef `bus_op_t` (BUS_RD, BUS_RDX)
- Sub-module `mesi_rr_pick`: combinational round-robin selector. Takes `req` and `rr_ptr`; returns `valid`, `owner` index and one-hot mask. Instantiated once.

## Test plan
- After reset, `req[1]` with op RD, no snoop hits:
  - `gnt`=0010 in cycles 1–4.
  - `snoop_rd`=1101 in cycle 1 only.
  - `done`=0010 in cycle 4 with `shared_resp`=0 and `flush_resp`=0.
- `req`=0101 in the same cycle after reset → cache 0 granted first, then cache 2. `rr_ptr` reads 3 after the second DONE.
- Cache 0 issues RDX and `snoop_flush[3]`=1 in the second SNOOP cycle:
  - FLUSH lasts 4 cycles.
  - `done[0]` in cycle 8 with `shared_resp`=1 and `flush_resp`=1.
  - `snoop_rdx`=1110 in cycle 1.
- All four `req` held continuously → grant order 0,1,2,3,0, with exactly one IDLE cycle between transactions.
- `reset` asserted in a SNOOP cycle → all outputs 0 the next cycle, no `done`. A new `req[2]` is then granted normally with `rr_ptr`=0.
- Owner cache 1 asserts its own `snoop_shared[1]` and `snoop_flush[1]` throughout → FLUSH is skipped, and `shared_resp`=0 and `flush_resp`=0.

Source files
------------

// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping-bus arbiter: sequencer states and bus op codes.
package mesi_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        SNOOP = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } bus_state_t;

    typedef enum logic {
        BUS_RD  = 1'b0,
        BUS_RDX = 1'b1
    } bus_op_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mesi_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_rr_ptr, wrapping.
module mesi_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_rr_ptr,
    output logic          o_valid,
    output logic [PW-1:0] o_owner,
    output logic [N-1:0]  o_owner_oh
);

    // One spare bit so rr_ptr + offset cannot overflow before the modulo wrap.
    logic [PW:0] w_idx;

    always_comb begin
        o_valid    = 1'b0;
        o_owner    = '0;
        o_owner_oh = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (PW+1)'(i_rr_ptr) + (PW+1)'(i);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!o_valid && i_req[w_idx[PW-1:0]]) begin
                o_valid                     = 1'b1;
                o_owner                     = w_idx[PW-1:0];
                o_owner_oh                  = '0;
                o_owner_oh[w_idx[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the MESI snooping bus:
// grant, one-cycle snoop broadcast, fixed snoop window, optional flush hold, done.
module mesi_bus_arbiter
    import mesi_bus_pkg::*;
#(
    parameter int unsigned N_CACHES     = 4,
    parameter int unsigned SNOOP_CYCLES = 2,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CACHES-1:0] req,
    input  logic [N_CACHES-1:0] req_rdx,
    input  logic [N_CACHES-1:0] snoop_shared,
    input  logic [N_CACHES-1:0] snoop_flush,
    output logic [N_CACHES-1:0] gnt,
    output logic [N_CACHES-1:0] snoop_rd,
    output logic [N_CACHES-1:0] snoop_rdx,
    output logic [N_CACHES-1:0] done,
    output logic                shared_resp,
    output logic                flush_resp,
    output logic                busy
);

    localparam int unsigned PW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
    localparam int unsigned CW = $clog2(max_u(SNOOP_CYCLES, FLUSH_CYCLES) + 1);
    localparam logic [CW-1:0] SNOOP_LAST = CW'(SNOOP_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
    localparam logic [PW-1:0] OWNER_MAX  = PW'(N_CACHES - 1);

    bus_state_t          r_state,    w_state_nxt;
    logic [PW-1:0]       r_owner,    w_owner_nxt;
    logic [N_CACHES-1:0] r_owner_oh, w_owner_oh_nxt;
    bus_op_t             r_op,       w_op_nxt;
    logic [PW-1:0]       r_rr_ptr,   w_rr_nxt;
    logic [CW-1:0]       r_cnt,      w_cnt_nxt;
    logic                r_sh_acc,   w_sh_nxt;
    logic                r_fl_acc,   w_fl_nxt;

    logic [N_CACHES-1:0] r_gnt,       w_gnt_nxt;
    logic [N_CACHES-1:0] r_snoop_rd,  w_snoop_rd_nxt;
    logic [N_CACHES-1:0] r_snoop_rdx, w_snoop_rdx_nxt;
    logic [N_CACHES-1:0] r_done,      w_done_nxt;
    logic                r_shared_resp, w_shared_resp_nxt;
    logic                r_flush_resp,  w_flush_resp_nxt;
    logic                r_busy,        w_busy_nxt;

    logic                w_pick_valid;
    logic [PW-1:0]       w_pick_owner;
    logic [N_CACHES-1:0] w_pick_oh;
    logic                w_hit_shared;
    logic                w_hit_flush;

    mesi_rr_pick #(
        .N  (N_CACHES),
        .PW (PW)
    ) u_rr_pick (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .o_valid    (w_pick_valid),
        .o_owner    (w_pick_owner),
        .o_owner_oh (w_pick_oh)
    );

    // Snoop hits from non-owners only; a flushing snooper also counts as sharing.
    assign w_hit_shared = |((snoop_shared | snoop_flush) & ~r_owner_oh);
    assign w_hit_flush  = |(snoop_flush & ~r_owner_oh);

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_owner_oh_nxt = r_owner_oh;
        w_op_nxt       = r_op;
        w_rr_nxt       = r_rr_ptr;
        w_cnt_nxt      = r_cnt;
        w_sh_nxt       = r_sh_acc;
        w_fl_nxt       = r_fl_acc;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt    = GRANT;
                    w_owner_nxt    = w_pick_owner;
                    w_owner_oh_nxt = w_pick_oh;
                    w_op_nxt       = req_rdx[w_pick_owner] ? BUS_RDX : BUS_RD;
                    w_cnt_nxt      = '0;
                end
            end
            GRANT: begin
                w_state_nxt = SNOOP;
                w_sh_nxt    = 1'b0;
                w_fl_nxt    = 1'b0;
                w_cnt_nxt   = SNOOP_LAST;
            end
            SNOOP: begin
                w_sh_nxt = r_sh_acc | w_hit_shared;
                w_fl_nxt = r_fl_acc | w_hit_flush;
                if (r_cnt == '0) begin
                    if (w_fl_nxt) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = FLUSH_LAST;
                    end else begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_rr_nxt    = (r_owner == OWNER_MAX) ? '0 : r_owner + PW'(1);
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register in step with it.
        w_gnt_nxt         = '0;
        w_snoop_rd_nxt    = '0;
        w_snoop_rdx_nxt   = '0;
        w_done_nxt        = '0;
        w_shared_resp_nxt = 1'b0;
        w_flush_resp_nxt  = 1'b0;
        w_busy_nxt        = (w_state_nxt != IDLE);

        if (w_state_nxt != IDLE) begin
            w_gnt_nxt = w_owner_oh_nxt;
        end
        if (w_state_nxt == GRANT) begin
            if (w_op_nxt == BUS_RDX) begin
                w_snoop_rdx_nxt = ~w_owner_oh_nxt;
            end else begin
                w_snoop_rd_nxt  = ~w_owner_oh_nxt;
            end
        end
        if (w_state_nxt == DONE) begin
            w_done_nxt        = w_owner_oh_nxt;
            w_shared_resp_nxt = w_sh_nxt;
            w_flush_resp_nxt  = w_fl_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_owner_oh    <= '0;
            r_op          <= BUS_RD;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_sh_acc      <= 1'b0;
            r_fl_acc      <= 1'b0;
            r_gnt         <= '0;
            r_snoop_rd    <= '0;
            r_snoop_rdx   <= '0;
            r_done        <= '0;
            r_shared_resp <= 1'b0;
            r_flush_resp  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_owner_oh    <= w_owner_oh_nxt;
            r_op          <= w_op_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sh_acc      <= w_sh_nxt;
            r_fl_acc      <= w_fl_nxt;
            r_gnt         <= w_gnt_nxt;
            r_snoop_rd    <= w_snoop_rd_nxt;
            r_snoop_rdx   <= w_snoop_rdx_nxt;
            r_done        <= w_done_nxt;
            r_shared_resp <= w_shared_resp_nxt;
            r_flush_resp  <= w_flush_resp_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign snoop_rd    = r_snoop_rd;
    assign snoop_rdx   = r_snoop_rdx;
    assign done        = r_done;
    assign shared_resp = r_shared_resp;
    assign flush_resp  = r_flush_resp;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed + randomized bench for mesi_bus_arbiter against a transaction-level model.
module tb_mesi_bus_arbiter;

    localparam int N = 4;
    localparam int S = 2;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, req_rdx, snoop_shared, snoop_flush;
    logic [3:0] gnt, snoop_rd, snoop_rdx, done;
    logic       shared_resp, flush_resp, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_rr    = 0;

    always #5 clk = ~clk;

    mesi_bus_arbiter #(
        .N_CACHES     (N),
        .SNOOP_CYCLES (S),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_rdx      (req_rdx),
        .snoop_shared (snoop_shared),
        .snoop_flush  (snoop_flush),
        .gnt          (gnt),
        .snoop_rd     (snoop_rd),
        .snoop_rdx    (snoop_rdx),
        .done         (done),
        .shared_resp  (shared_resp),
        .flush_resp   (flush_resp),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] erd,
                             input logic [3:0] erdx, input logic [3:0] ed, input logic esh,
                             input logic efl, input logic ebusy);
        chk({tag, ".gnt"},         32'(gnt),         32'(eg));
        chk({tag, ".snoop_rd"},    32'(snoop_rd),    32'(erd));
        chk({tag, ".snoop_rdx"},   32'(snoop_rdx),   32'(erdx));
        chk({tag, ".done"},        32'(done),        32'(ed));
        chk({tag, ".shared_resp"}, 32'(shared_resp), 32'(esh));
        chk({tag, ".flush_resp"},  32'(flush_resp),  32'(efl));
        chk({tag, ".busy"},        32'(busy),        32'(ebusy));
    endtask

    // Snooper behaviour: 0 quiet, 1 random, 2 cache 3 flushes in 2nd window cycle, 3 owner hits itself.
    task automatic drive_snoop(input int mode, input int idx, input logic [3:0] oh);
        case (mode)
            1: begin
                snoop_shared = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
                snoop_flush  = ($urandom % 5 == 0) ? 4'($urandom) : 4'b0000;
            end
            2: begin
                snoop_shared = 4'b0000;
                snoop_flush  = (idx == 1) ? 4'b1000 : 4'b0000;
            end
            3: begin
                snoop_shared = oh;
                snoop_flush  = oh;
            end
            default: begin
                snoop_shared = 4'b0000;
                snoop_flush  = 4'b0000;
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; req_rdx = '0; snoop_shared = '0; snoop_flush = '0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        m_rr  = 0;
    endtask

    // Called at the falling edge of an idle cycle; returns at the falling edge of the following idle cycle.
    task automatic run_txn(input logic [3:0] reqv, input logic [3:0] rdxv, input int mode, input bit drop);
        int         owner;
        logic [3:0] oh, mask;
        logic       op, esh, efl;
        req = reqv; req_rdx = rdxv;
        owner = -1;
        for (int k = 0; k < N; k++) begin
            if (owner < 0 && reqv[(m_rr + k) % N]) owner = (m_rr + k) % N;
        end
        oh   = 4'b0001 << owner;
        mask = ~oh;
        op   = rdxv[owner];
        esh  = 1'b0;
        efl  = 1'b0;
        drive_snoop(mode, -1, oh);
        @(negedge clk);
        check_all("grant", oh, op ? 4'h0 : mask, op ? mask : 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        if (drop) req = reqv & ~oh;
        req_rdx = 4'($urandom);
        drive_snoop(mode, -1, oh);
        for (int c = 0; c < S; c++) begin
            @(negedge clk);
            check_all("snoop", oh, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            drive_snoop(mode, c, oh);
            esh = esh | (|((snoop_shared | snoop_flush) & mask));
            efl = efl | (|(snoop_flush & mask));
        end
        if (efl) begin
            for (int c = 0; c < F; c++) begin
                @(negedge clk);
                check_all("flush", oh, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
                drive_snoop(mode, -1, oh);
            end
        end
        @(negedge clk);
        check_all("done", oh, 4'h0, 4'h0, oh, esh, efl, 1'b1);
        m_rr = (owner + 1) % N;
        drive_snoop(mode, -1, oh);
        @(negedge clk);
        check_all("post_idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Single RD from cache 1, quiet snoopers.
        do_reset();
        run_txn(4'b0010, 4'b0000, 0, 1'b0);
        req = '0;

        // Simultaneous requests 0 and 2, then a full request set must go to cache 3.
        do_reset();
        run_txn(4'b0101, 4'b0000, 0, 1'b0);
        run_txn(4'b0100, 4'b0000, 1, 1'b0);
        run_txn(4'b1111, 4'b0000, 0, 1'b0);
        req = '0;

        // Cache 0 RDX, cache 3 flushes late in the window.
        do_reset();
        run_txn(4'b0001, 4'b0001, 2, 1'b0);
        req = '0;

        // All four held: grants 0,1,2,3,0.
        do_reset();
        for (int t = 0; t < 5; t++) run_txn(4'b1111, 4'($urandom), 1, 1'b0);
        req = '0;

        // Reset in the middle of a snoop window.
        do_reset();
        run_txn(4'b0100, 4'b0000, 0, 1'b0);
        req = 4'b0001; req_rdx = 4'b0000;
        @(negedge clk);
        check_all("abort_grant", 4'b0001, 4'b1110, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_all("abort_snoop", 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1; req = '0;
        @(negedge clk);
        check_all("abort_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        m_rr  = 0;
        run_txn(4'b1100, 4'b0000, 0, 1'b0);
        req = '0;

        // Owner's own snoop bits never count.
        run_txn(4'b0010, 4'b0000, 3, 1'b0);
        req = '0;

        // Randomized traffic, occasional mid-transaction request drop and idle gaps.
        for (int t = 0; t < 40; t++) begin
            run_txn(4'($urandom_range(1, 15)), 4'($urandom), 1, ($urandom % 4) == 0);
            if ($urandom % 2 == 0) begin
                req = '0;
                @(negedge clk);
                check_all("gap", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            end
        end
        req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
